// File: rtl/playback_pkg.sv
// Shared definitions for the playback control slice.
//   ST_*          2-bit FSM state encodings, also driven on the state debug port
//   ADDER_NORMAL  timer increment per step during normal playback
package playback_pkg;

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_FFWD    = 2'd3;

  localparam logic [5:0] ADDER_NORMAL = 6'd1;

endpackage

// File: rtl/tick_divider.sv
// Free-running tick divider producing the timer's square-wave clock.
//   clk, rst   system clock, asynchronous active-high reset
//   run        advance the divider this cycle
//   clear      force cnt=0 and timer_clk=0 (wins over run)
//   cnt        current divider phase, 0..DIV-1
//   timer_clk  registered square wave, rises on the wrap DIV-1 -> 0
module tick_divider #(
  parameter int unsigned DIV = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    clear,
  output logic [$clog2(DIV)-1:0]  cnt,
  output logic                    timer_clk
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tclk_q, tclk_d;

  always_comb begin
    cnt_d  = cnt_q;
    tclk_d = tclk_q;
    if (clear) begin
      cnt_d  = '0;
      tclk_d = 1'b0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tclk_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF) tclk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tclk_q <= tclk_d;
    end
  end

  assign cnt       = cnt_q;
  assign timer_clk = tclk_q;

endmodule

// File: rtl/playback_tick_ctrl.sv
// Playback control ahead of the elapsed-time timer: turns play/pause, stop and
// fast-forward buttons into timer_clk, count, adder and timer_reset.
//   clk, reset     system clock, asynchronous active-high reset
//   btn_play       async level, each rising edge toggles play/pause
//   btn_stop       async level, rising edge stops
//   btn_ff         async level, held = fast-forward while playing
//   end_of_track   synchronous 1-cycle pulse, stops playback
//   timer_clk      timer step clock (rising edge = one step)
//   count, adder   timer enable and increment, stable across timer_clk rises
//   timer_reset    timer clear level, high while stopped
//   state          current FSM state
module playback_tick_ctrl
  import playback_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned FF_STEP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_play,
  input  logic       btn_stop,
  input  logic       btn_ff,
  input  logic       end_of_track,
  output logic       timer_clk,
  output logic       count,
  output logic [5:0] adder,
  output logic       timer_reset,
  output logic [1:0] state
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
  localparam logic [5:0]    ADDER_FF = 6'(FF_STEP);

  // [0] metastable stage, [1] synchronised level, [2] previous synchronised level
  logic [2:0] play_sh_q, play_sh_d;
  logic [2:0] stop_sh_q, stop_sh_d;
  logic [1:0] ff_sh_q,   ff_sh_d;
  logic [1:0] state_q,   state_d;
  logic       count_q,   count_d;
  logic [5:0] adder_q,   adder_d;

  logic          play_pulse, stop_pulse, ff_lvl;
  logic [CW-1:0] div_cnt;
  logic          div_run, div_clear;

  always_comb begin
    play_sh_d  = {play_sh_q[1:0], btn_play};
    stop_sh_d  = {stop_sh_q[1:0], btn_stop};
    ff_sh_d    = {ff_sh_q[0], btn_ff};
    play_pulse = play_sh_q[1] & ~play_sh_q[2];
    stop_pulse = stop_sh_q[1] & ~stop_sh_q[2];
    ff_lvl     = ff_sh_q[1];
  end

  always_comb begin
    state_d = state_q;
    if (stop_pulse || end_of_track) begin
      state_d = ST_STOPPED;
    end else if (play_pulse) begin
      case (state_q)
        ST_STOPPED: state_d = ST_PLAYING;
        ST_PLAYING: state_d = ST_PAUSED;
        ST_PAUSED:  state_d = ST_PLAYING;
        default:    state_d = ST_PAUSED;
      endcase
    end else if (state_q == ST_PLAYING && ff_lvl) begin
      state_d = ST_FFWD;
    end else if (state_q == ST_FFWD && !ff_lvl) begin
      state_d = ST_PLAYING;
    end
  end

  // Clear follows the next state so the divider and timer_clk drop in the
  // same cycle the FSM enters STOPPED; run follows the current state so the
  // first edge after leaving STOPPED lands exactly DIV cycles later.
  assign div_run   = (state_q == ST_PLAYING) || (state_q == ST_FFWD);
  assign div_clear = (state_d == ST_STOPPED);

  tick_divider #(.DIV(DIV)) u_div (
    .clk       (clk),
    .rst       (reset),
    .run       (div_run),
    .clear     (div_clear),
    .cnt       (div_cnt),
    .timer_clk (timer_clk)
  );

  // count/adder only move in the low phase away from the wrap, so they are
  // settled at every timer_clk rise; stopping clears them regardless.
  always_comb begin
    count_d = count_q;
    adder_d = adder_q;
    if (state_d == ST_STOPPED) begin
      count_d = 1'b0;
      adder_d = '0;
    end else if (!timer_clk && div_cnt != LAST) begin
      case (state_q)
        ST_PLAYING: begin count_d = 1'b1; adder_d = ADDER_NORMAL; end
        ST_FFWD:    begin count_d = 1'b1; adder_d = ADDER_FF;     end
        default:    begin count_d = 1'b0; adder_d = '0;           end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      play_sh_q <= '0;
      stop_sh_q <= '0;
      ff_sh_q   <= '0;
      state_q   <= ST_STOPPED;
      count_q   <= 1'b0;
      adder_q   <= '0;
    end else begin
      play_sh_q <= play_sh_d;
      stop_sh_q <= stop_sh_d;
      ff_sh_q   <= ff_sh_d;
      state_q   <= state_d;
      count_q   <= count_d;
      adder_q   <= adder_d;
    end
  end

  assign state       = state_q;
  assign count       = count_q;
  assign adder       = adder_q;
  assign timer_reset = (state_q == ST_STOPPED);

endmodule
